uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter CLOCK_PER_BAUD, default 138, clock cycles per UART bit (16 MHz / 115200).
REQ-002 Parameter FRAME_BITS, default 10, bits per UART frame (start + 8 data + stop).
REQ-003 Derived constant PERIOD = CLOCK_PER_BAUD*FRAME_BITS; PERIOD >= 3 SHALL hold, else elaboration error.
REQ-004 i_clk  input  1  single system clock; all logic rising-edge.
REQ-005 i_reset  input  1  reset, synchronous, active-high.
REQ-006 i_a_data  input  8  requester A byte.
REQ-007 i_a_valid  input  1  requester A byte valid.
REQ-008 o_a_ready  output  1  requester A byte accepted this cycle.
REQ-009 i_b_data / i_b_valid / o_b_ready  in/in/out  8/1/1  requester B, same semantics as A.
REQ-010 o_uart_write_data  output  8  byte to uart i_write_data.
REQ-011 o_uart_write_enable  output  1  one-cycle write strobe to uart i_write_enable.
REQ-012 o_grant_id  output  1  requester of last accepted byte (0=A, 1=B).
REQ-013 o_busy  output  1  high whenever state != IDLE.

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT; state register, 8-bit data latch, down-counter of width clog2(PERIOD), 1-bit last-grant pointer.
REQ-015 IDLE: winner chosen combinationally among valid requesters; o_x_ready = (state==IDLE) & valid & winner==x; at most one ready high per cycle.
REQ-016 Transfer occurs when valid & ready on the same edge; data latched, o_grant_id and pointer updated, next state ISSUE.
REQ-017 Requesters hold data stable while valid and not ready; arbiter never drops a valid.
REQ-018 Round-robin: both valid -> grant goes to requester not equal to pointer; single valid -> that requester wins regardless of pointer.
REQ-019 ISSUE (exactly one cycle): o_uart_write_enable=1, o_uart_write_data=latched byte; counter loaded PERIOD-3; next WAIT.
REQ-020 WAIT: counter decrements each cycle; at counter==0 next state IDLE; o_uart_write_enable=0 throughout.
REQ-021 Throughput: with continuous valid, transfers occur every PERIOD cycles and write strobes are exactly PERIOD cycles apart.
REQ-022 Latency: acceptance at cycle T -> write strobe at T+1.
REQ-023 o_uart_write_data holds last issued byte outside ISSUE; o_uart_write_enable never high two consecutive cycles.
REQ-024 Valid deasserted in IDLE before acceptance -> no transfer, no state change.

Reset
REQ-025 While i_reset high: o_uart_write_enable=0, o_a_ready=o_b_ready=0, o_uart_write_data=8'h00, o_grant_id=0, pointer=1 (A wins first tie), state=WAIT, counter=PERIOD-1, o_busy=1.
REQ-026 Reset mid-ISSUE or mid-WAIT aborts the controller sequence only; the uart is not reset, so post-reset WAIT guards against an in-flight frame.
REQ-027 First possible acceptance is the PERIOD-th cycle after the first cycle with i_reset low.

Structure
REQ-028 Shared package uart_pkg: state encoding (IDLE/ISSUE/WAIT), default CLOCK_PER_BAUD and FRAME_BITS, shared by uart and controller.
REQ-029 One sub-module: uart_frame_timer (loadable down-counter, load value and zero flag); arbitration and FSM stay in uart_tx_arbiter.

Verification (CLOCK_PER_BAUD=4, FRAME_BITS=10, PERIOD=40)
REQ-030 Reset release, A valid 8'h41 held -> o_a_ready high exactly 40 cycles after reset release; strobe with 8'h41 next cycle.
REQ-031 A and B valid continuously (A=8'h11, B=8'h22) -> strobes alternate 11,22,11,22, spaced exactly 40 cycles; o_grant_id alternates 0,1,0,1.
REQ-032 Only B valid, 3 bytes 8'hA0..8'hA2 -> all granted to B in order, 40 cycles apart; o_a_ready never high.
REQ-033 Reset asserted 5 cycles after a strobe, A valid 8'h55 -> no strobe during reset; next strobe 41 cycles after reset release, data 8'h55.
REQ-034 A valid pulsed 1 cycle during WAIT, then dropped -> no ready, no strobe, state returns IDLE and stays.
REQ-035 Assertions throughout: never both readies high; strobe never in consecutive cycles; strobe spacing >= 40 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit path: controller state encoding,
// default baud/frame timing, and a helper for the frame period in clocks.
package uart_pkg;

    // IDLE: arbitrating. ISSUE: one-cycle write strobe. WAIT: frame in flight.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // 16 MHz system clock, 115200 baud.
    localparam int unsigned DEFAULT_CLOCK_PER_BAUD = 138;
    // Start bit + 8 data bits + stop bit.
    localparam int unsigned DEFAULT_FRAME_BITS     = 10;

    function automatic int unsigned frame_period(input int unsigned clock_per_baud,
                                                 input int unsigned frame_bits);
        return clock_per_baud * frame_bits;
    endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// uart_frame_timer
// Loadable down-counter that measures one UART frame time.
// Ports:
//   i_clk        system clock (rising edge)
//   i_reset      synchronous active-high reset, loads RESET_VALUE
//   i_load       load i_load_value this cycle (has priority over i_dec)
//   i_load_value value to load
//   i_dec        decrement by one; holds at zero
//   o_zero       counter currently equals zero
module uart_frame_timer #(
    parameter int unsigned W           = 8,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_value,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= W'(RESET_VALUE);
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter between two byte requesters (A, B) feeding a UART
// transmitter. Accepts one byte, issues a one-cycle write strobe, then waits
// a full frame time before accepting the next byte.
//
// Handshake: a byte moves on any rising edge where valid and ready are both
// high. Ready is only offered in IDLE, never depends on a requester that is
// not valid, and at most one ready is high per cycle. Requesters keep data
// stable while valid and not yet ready.
//
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_a_data/i_a_valid/o_a_ready   requester A
//   i_b_data/i_b_valid/o_b_ready   requester B
//   o_uart_write_data              byte for the uart (holds last issued byte)
//   o_uart_write_enable            one-cycle write strobe
//   o_grant_id                     requester of last accepted byte (0=A, 1=B)
//   o_busy                         controller not in IDLE
//   o_dbg_state                    current controller state
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_PER_BAUD = DEFAULT_CLOCK_PER_BAUD,
    parameter int unsigned FRAME_BITS     = DEFAULT_FRAME_BITS
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_a_data,
    input  logic       i_a_valid,
    output logic       o_a_ready,
    input  logic [7:0] i_b_data,
    input  logic       i_b_valid,
    output logic       o_b_ready,
    output logic [7:0] o_uart_write_data,
    output logic       o_uart_write_enable,
    output logic       o_grant_id,
    output logic       o_busy,
    output state_t     o_dbg_state
);

    localparam int unsigned PERIOD = frame_period(CLOCK_PER_BAUD, FRAME_BITS);
    localparam int unsigned CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    if (PERIOD < 3) begin : g_period_check
        $error("uart_tx_arbiter: CLOCK_PER_BAUD*FRAME_BITS must be at least 3");
    end

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_data;
    logic       r_grant_id;
    logic       r_ptr;          // last granted requester
    logic       w_winner;
    logic       w_transfer;
    logic       w_a_ready;
    logic       w_b_ready;
    logic       w_load;
    logic       w_dec;
    logic       w_zero;

    // Tie goes to the requester that was not granted last; a lone valid
    // requester wins regardless of the pointer.
    assign w_winner = (i_a_valid && i_b_valid) ? ~r_ptr : ~i_a_valid;

    // ISSUE lasts one cycle and IDLE->ISSUE costs one more, so the timer
    // covers the remaining PERIOD-2 cycles of the frame: PERIOD-3 down to 0.
    // After reset it starts at PERIOD-1 so a frame the uart may still be
    // sending is fully covered before the first acceptance.
    uart_frame_timer #(
        .W           (CW),
        .RESET_VALUE (PERIOD - 1)
    ) u_frame_timer (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_load       (w_load),
        .i_load_value (CW'(PERIOD - 3)),
        .i_dec        (w_dec),
        .o_zero       (w_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_WAIT;
            r_data     <= 8'h00;
            r_grant_id <= 1'b0;
            r_ptr      <= 1'b1;
        end else begin
            r_state <= w_next_state;
            if (w_transfer) begin
                r_data     <= w_winner ? i_b_data : i_a_data;
                r_grant_id <= w_winner;
                r_ptr      <= w_winner;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_transfer   = 1'b0;
        w_a_ready    = 1'b0;
        w_b_ready    = 1'b0;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((i_a_valid || i_b_valid) && !i_reset) begin
                    w_transfer   = 1'b1;
                    w_a_ready    = ~w_winner;
                    w_b_ready    = w_winner;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_load       = 1'b1;
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                w_dec = 1'b1;
                if (w_zero) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_WAIT;
            end
        endcase
    end

    // Outputs are forced to their reset values for every cycle reset is
    // high, including the first one before the state register has reacted.
    assign o_a_ready           = w_a_ready;
    assign o_b_ready           = w_b_ready;
    assign o_uart_write_enable = (r_state == ST_ISSUE) && !i_reset;
    assign o_uart_write_data   = i_reset ? 8'h00 : r_data;
    assign o_grant_id          = i_reset ? 1'b0 : r_grant_id;
    assign o_busy              = i_reset || (r_state != ST_IDLE);
    assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int P = 40;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] i_a_data = 8'h00;
  logic       i_a_valid = 1'b0;
  logic [7:0] i_b_data = 8'h00;
  logic       i_b_valid = 1'b0;
  logic       o_a_ready, o_b_ready, o_uart_write_enable, o_grant_id, o_busy;
  logic [7:0] o_uart_write_data;
  state_t     o_dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  uart_tx_arbiter #(.CLOCK_PER_BAUD(4), .FRAME_BITS(10)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_a_data(i_a_data), .i_a_valid(i_a_valid), .o_a_ready(o_a_ready),
    .i_b_data(i_b_data), .i_b_valid(i_b_valid), .o_b_ready(o_b_ready),
    .o_uart_write_data(o_uart_write_data), .o_uart_write_enable(o_uart_write_enable),
    .o_grant_id(o_grant_id), .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model + scoreboard ----------------
  // The model only tracks cycle numbers: the cycle from which the arbiter is
  // idle, the cycle the next strobe is due, last byte/grant, and the pointer.
  logic [7:0] exp_q[$];
  int   m_idle_from = 0;
  int   m_strobe_at = -1;
  int   m_last_strobe = -1000;
  logic [7:0] m_data = 8'h00;
  logic m_gid = 1'b0;
  logic m_ptr = 1'b1;
  logic m_prev_we = 1'b0;
  int   n_strobes = 0;
  int   n_a_ready = 0;

  always @(negedge clk) begin
    logic idle, win, e_a, e_b, e_we;
    logic [7:0] got;
    if (o_uart_write_enable === 1'b1) n_strobes++;
    if (o_a_ready === 1'b1) n_a_ready++;
    check("one_ready", {31'd0, o_a_ready & o_b_ready}, 32'd0);
    if (i_reset) begin
      check("rst_we", {31'd0, o_uart_write_enable}, 32'd0);
      check("rst_a_ready", {31'd0, o_a_ready}, 32'd0);
      check("rst_b_ready", {31'd0, o_b_ready}, 32'd0);
      check("rst_data", {24'd0, o_uart_write_data}, 32'd0);
      check("rst_gid", {31'd0, o_grant_id}, 32'd0);
      check("rst_busy", {31'd0, o_busy}, 32'd1);
      m_idle_from = cyc + 1 + P;
      m_strobe_at = -1;
      m_data = 8'h00;
      m_gid = 1'b0;
      m_ptr = 1'b1;
      exp_q.delete();
      m_prev_we = 1'b0;
    end else begin
      idle = (cyc >= m_idle_from);
      if (i_a_valid && i_b_valid) win = ~m_ptr;
      else win = i_b_valid && !i_a_valid;
      e_a = idle && i_a_valid && !win;
      e_b = idle && i_b_valid && win;
      e_we = (cyc == m_strobe_at);
      check("a_ready", {31'd0, o_a_ready}, {31'd0, e_a});
      check("b_ready", {31'd0, o_b_ready}, {31'd0, e_b});
      check("we", {31'd0, o_uart_write_enable}, {31'd0, e_we});
      check("data", {24'd0, o_uart_write_data}, {24'd0, m_data});
      check("gid", {31'd0, o_grant_id}, {31'd0, m_gid});
      check("busy", {31'd0, o_busy}, {31'd0, !idle});
      if (o_uart_write_enable === 1'b1) begin
        check("we_consecutive", {31'd0, m_prev_we}, 32'd0);
        check("strobe_spacing_ok", {31'd0, (cyc - m_last_strobe) >= P}, 32'd1);
        m_last_strobe = cyc;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_strobe", 32'd1, 32'd0);
        end else begin
          got = exp_q.pop_front();
          check("sb_data", {24'd0, o_uart_write_data}, {24'd0, got});
        end
      end
      m_prev_we = (o_uart_write_enable === 1'b1);
      if (e_a || e_b) begin
        m_data = win ? i_b_data : i_a_data;
        m_gid = win;
        m_ptr = win;
        m_strobe_at = cyc + 1;
        m_idle_from = cyc + P;
        exp_q.push_back(m_data);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input bit which, input int budget, input string tag, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if ((which ? o_b_ready : o_a_ready) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_strobe(input int budget, input string tag, output int at,
                             output logic [7:0] d, output logic g);
    at = -1;
    d = 8'h00;
    g = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (o_uart_write_enable === 1'b1) begin
        at = cyc;
        d = o_uart_write_data;
        g = o_grant_id;
        break;
      end
    end
    if (at < 0) check({tag, "_strobe_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_strobe(input string tag, input logic [7:0] exp_d);
    @(negedge clk);
    check({tag, "_we"}, {31'd0, o_uart_write_enable}, 32'd1);
    check({tag, "_data"}, {24'd0, o_uart_write_data}, {24'd0, exp_d});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int rel, rc, prev, sc, snap_s, snap_a;
    logic [7:0] d;
    logic g;

    // Reset with A already valid: nothing may be offered.
    i_a_valid = 1'b1;
    i_a_data = 8'h41;
    @(negedge clk);
    check("t0_busy_in_reset", {31'd0, o_busy}, 32'd1);
    check("t0_a_ready_in_reset", {31'd0, o_a_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    rel = cyc;

    // First acceptance exactly 40 cycles after release, strobe next cycle.
    wait_ready(1'b0, 60, "t1", rc);
    check("t1_latency", rc - rel, 32'd40);
    @(posedge clk);
    #1 i_a_valid = 1'b0;
    check_strobe("t1", 8'h41);

    // Both valid continuously after a fresh reset: A first, then alternate.
    @(posedge clk);
    #1 i_reset = 1'b1;
    i_a_valid = 1'b1; i_a_data = 8'h11;
    i_b_valid = 1'b1; i_b_data = 8'h22;
    repeat (2) @(posedge clk);
    #1 i_reset = 1'b0;
    rel = cyc;
    for (int k = 0; k < 4; k++) begin
      wait_strobe(60, "t2", sc, d, g);
      check("t2_cycle", sc - rel, 41 + 40 * k);
      check("t2_data", {24'd0, d}, (k % 2 == 0) ? 32'h11 : 32'h22);
      check("t2_gid", {31'd0, g}, k % 2);
    end
    @(posedge clk);
    #1 i_a_valid = 1'b0; i_b_valid = 1'b0;

    // Only B valid, three bytes in order, pointer already at B.
    snap_a = n_a_ready;
    i_b_valid = 1'b1; i_b_data = 8'hA0;
    prev = -1;
    for (int k = 0; k < 3; k++) begin
      wait_ready(1'b1, 100, "t3", rc);
      if (k > 0) check("t3_spacing", rc - prev, 32'd40);
      prev = rc;
      @(posedge clk);
      #1;
      if (k == 2) i_b_valid = 1'b0;
      else i_b_data = 8'hA0 + 8'(k + 1);
      check_strobe("t3", 8'hA0 + 8'(k));
    end
    check("t3_no_a_ready", n_a_ready - snap_a, 32'd0);

    // Reset 5 cycles after a strobe with A holding 8'h55.
    i_a_valid = 1'b1; i_a_data = 8'h33;
    wait_ready(1'b0, 100, "t4a", rc);
    @(posedge clk);
    #1 i_a_data = 8'h55;
    check_strobe("t4a", 8'h33);
    repeat (5) @(posedge clk);
    #1 i_reset = 1'b1;
    snap_s = n_strobes;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    rel = cyc;
    check("t4_no_strobe_in_reset", n_strobes - snap_s, 32'd0);
    wait_ready(1'b0, 60, "t4b", rc);
    check("t4_latency", rc - rel, 32'd40);
    @(posedge clk);
    #1 i_a_valid = 1'b0;
    check_strobe("t4b", 8'h55);
    check("t4_strobe_cycle", cyc - rel, 32'd41);

    // One-cycle A pulse during WAIT: dropped before IDLE, never accepted.
    repeat (10) @(posedge clk);
    #1 i_a_valid = 1'b1; i_a_data = 8'h77;
    @(posedge clk);
    #1 i_a_valid = 1'b0;
    snap_s = n_strobes;
    snap_a = n_a_ready;
    repeat (80) @(posedge clk);
    @(negedge clk);
    check("t5_no_strobe", n_strobes - snap_s, 32'd0);
    check("t5_no_ready", n_a_ready - snap_a, 32'd0);
    check("t5_idle_busy", {31'd0, o_busy}, 32'd0);
    check("t5_idle_state", {30'd0, o_dbg_state}, {30'd0, ST_IDLE});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
